// File: rtl/branch_predictor_gshare_if.sv
// Fetch/resolve interface of the gshare predictor: IF probe, ID BTB install, EX resolve, stats.
interface branch_predictor_gshare_if #(
    parameter int WORD_SIZE = 16,
    parameter int GHR_BITS  = 6
);
    logic                 ready;
    logic [WORD_SIZE-1:0] pc;
    logic                 tag_match;
    logic                 pred_taken;
    logic [WORD_SIZE-1:0] npc;
    logic [GHR_BITS-1:0]  pred_ghr;
    logic                 update_btb;
    logic [WORD_SIZE-1:0] pc_btb;
    logic [WORD_SIZE-1:0] btb_target;
    logic                 update_pht;
    logic [WORD_SIZE-1:0] pc_outcome;
    logic [GHR_BITS-1:0]  ghr_outcome;
    logic                 branch_outcome;
    logic                 mispredict;
    logic [31:0]          stat_branches;
    logic [31:0]          stat_mispredicts;

    modport master (
        output pc, update_btb, pc_btb, btb_target, update_pht, pc_outcome,
               ghr_outcome, branch_outcome, mispredict,
        input  ready, tag_match, pred_taken, npc, pred_ghr, stat_branches, stat_mispredicts
    );
    modport slave (
        input  pc, update_btb, pc_btb, btb_target, update_pht, pc_outcome,
               ghr_outcome, branch_outcome, mispredict,
        output ready, tag_match, pred_taken, npc, pred_ghr, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Tagged direct-mapped BTB plus gshare PHT, cleared one entry per cycle after reset.
// Optional resolved-branch / mispredict counters are built when BP_STATS_EN is defined.
module branch_predictor_gshare #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 8,
    parameter int GHR_BITS  = 6,
    parameter int CTR_BITS  = 2
) (
    input logic clk,
    input logic reset,
    branch_predictor_gshare_if.slave bp
);
    localparam int DEPTH = 2**IDX_BITS;
    localparam int TAG_W = WORD_SIZE - IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;

    logic [IDX_BITS-1:0] init_idx;
    logic [GHR_BITS-1:0] ghr, ghr_nxt;
    logic [DEPTH-1:0]    valid;
    logic [TAG_W-1:0]    tags    [DEPTH];
    logic [WORD_SIZE-1:0] targets [DEPTH];
    logic [CTR_BITS-1:0] pht     [DEPTH];

    logic                ready;
    logic [IDX_BITS-1:0] idx, pidx, uidx, bidx;
    logic [CTR_BITS-1:0] ctr, ctr_nxt;

    // FSM: INIT walks every index once, then RUN forever until reset
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_idx == {IDX_BITS{1'b1}}) state_nxt = RUN;
    end

    assign ready = (state == RUN);

    // Prediction path
    assign idx           = bp.pc[IDX_BITS-1:0];
    assign pidx          = idx ^ IDX_BITS'(ghr);
    assign bp.ready      = ready;
    assign bp.tag_match  = ready & valid[idx] & (bp.pc[WORD_SIZE-1:IDX_BITS] == tags[idx]);
    assign bp.pred_taken = bp.tag_match & pht[pidx][CTR_BITS-1];
    assign bp.npc        = bp.pred_taken ? targets[idx] : bp.pc + WORD_SIZE'(1);
    assign bp.pred_ghr   = ghr;

    // Update path: history is rebuilt from the resolving branch's own GHR
    assign bidx = bp.pc_btb[IDX_BITS-1:0];
    assign uidx = bp.pc_outcome[IDX_BITS-1:0] ^ IDX_BITS'(bp.ghr_outcome);
    assign ctr  = pht[uidx];

    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_nxt = bp.branch_outcome;
        end else begin : g_ghrn
            assign ghr_nxt = {bp.ghr_outcome[GHR_BITS-2:0], bp.branch_outcome};
        end
    endgenerate

    always_comb begin
        ctr_nxt = ctr;
        if (bp.branch_outcome && ctr != {CTR_BITS{1'b1}}) ctr_nxt = ctr + CTR_BITS'(1);
        else if (!bp.branch_outcome && ctr != '0)        ctr_nxt = ctr - CTR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx <= '0;
            ghr      <= '0;
        end else if (state == INIT) begin
            valid[init_idx]   <= 1'b0;
            tags[init_idx]    <= '0;
            targets[init_idx] <= '0;
            pht[init_idx]     <= CTR_INIT;
            init_idx          <= init_idx + IDX_BITS'(1);
        end else begin
            if (bp.update_btb) begin
                valid[bidx]   <= 1'b1;
                tags[bidx]    <= bp.pc_btb[WORD_SIZE-1:IDX_BITS];
                targets[bidx] <= bp.btb_target;
            end
            if (bp.update_pht) begin
                pht[uidx] <= ctr_nxt;
                ghr       <= ghr_nxt;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt, mp_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (ready && bp.update_pht) begin
            if (br_cnt != '1)                   br_cnt <= br_cnt + 32'd1;
            if (bp.mispredict && mp_cnt != '1)  mp_cnt <= mp_cnt + 32'd1;
        end
    end

    assign bp.stat_branches    = br_cnt;
    assign bp.stat_mispredicts = mp_cnt;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare (IDX_BITS=4, GHR_BITS=4) with a table-level model.
module tb_branch_predictor_gshare;
    localparam int WS = 16;
    localparam int IB = 4;
    localparam int GB = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    branch_predictor_gshare_if #(.WORD_SIZE(WS), .GHR_BITS(GB)) bp ();

    branch_predictor_gshare #(.WORD_SIZE(WS), .IDX_BITS(IB), .GHR_BITS(GB), .CTR_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tables as plain arrays, readiness as a cycle count since reset
    bit m_on = 0;
    int m_cnt = 0;
    int m_ghr = 0;
    int m_br = 0, m_mp = 0;
    bit m_valid [N];
    int m_tag [N];
    int m_tgt [N];
    int m_pht [N];

    always @(posedge clk) begin
        if (reset) begin
            m_on = 1; m_cnt = 0; m_ghr = 0; m_br = 0; m_mp = 0;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_pht[i] = 2;
            end
        end else if (m_on) begin
            if (m_cnt < N) m_cnt++;
            else begin
                if (bp.update_btb) begin
                    m_valid[bp.pc_btb % N] = 1;
                    m_tag[bp.pc_btb % N]   = bp.pc_btb / N;
                    m_tgt[bp.pc_btb % N]   = bp.pc_btb === 16'hx ? 0 : int'(bp.btb_target);
                end
                if (bp.update_pht) begin
                    int u;
                    u = (bp.pc_outcome % N) ^ int'(bp.ghr_outcome);
                    if (bp.branch_outcome) m_pht[u] = (m_pht[u] < 3) ? m_pht[u] + 1 : 3;
                    else                   m_pht[u] = (m_pht[u] > 0) ? m_pht[u] - 1 : 0;
                    m_ghr = ((int'(bp.ghr_outcome) * 2) + int'(bp.branch_outcome)) % N;
                    m_br++;
                    if (bp.mispredict) m_mp++;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (m_on) begin
            bit rdy, hit, tk;
            int i, e_npc;
            rdy   = (m_cnt == N);
            i     = bp.pc % N;
            hit   = rdy && m_valid[i] && (m_tag[i] == bp.pc / N);
            tk    = hit && (m_pht[i ^ m_ghr] >= 2);
            e_npc = tk ? m_tgt[i] : (int'(bp.pc) + 1) % 65536;
            chk("cmp_ready", {31'b0, bp.ready}, {31'b0, rdy});
            chk("cmp_tag_match", {31'b0, bp.tag_match}, {31'b0, hit});
            chk("cmp_pred_taken", {31'b0, bp.pred_taken}, {31'b0, tk});
            chk("cmp_npc", {16'b0, bp.npc}, e_npc);
            chk("cmp_pred_ghr", {28'b0, bp.pred_ghr}, m_ghr);
`ifdef BP_STATS_EN
            chk("cmp_stat_br", bp.stat_branches, m_br);
            chk("cmp_stat_mp", bp.stat_mispredicts, m_mp);
`else
            chk("cmp_stat_br", bp.stat_branches, 0);
            chk("cmp_stat_mp", bp.stat_mispredicts, 0);
`endif
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic probe(input logic [15:0] p);
        bp.pc = p; #1;
    endtask

    task automatic pht_pulse(input logic [15:0] p, input logic [3:0] g, input logic t, input logic m);
        bp.update_pht = 1; bp.pc_outcome = p; bp.ghr_outcome = g;
        bp.branch_outcome = t; bp.mispredict = m;
        tick();
        bp.update_pht = 0; bp.mispredict = 0;
    endtask

    task automatic btb_install(input logic [15:0] p, input logic [15:0] t);
        bp.update_btb = 1; bp.pc_btb = p; bp.btb_target = t;
        tick();
        bp.update_btb = 0;
    endtask

    initial begin
        bp.pc = 0; bp.update_btb = 0; bp.pc_btb = 0; bp.btb_target = 0;
        bp.update_pht = 0; bp.pc_outcome = 0; bp.ghr_outcome = 0;
        bp.branch_outcome = 0; bp.mispredict = 0;

        // Reset, then exactly 16 init cycles
        reset = 1; @(posedge clk); tick(); reset = 0;
        for (int k = 0; k < N; k++) begin
            chk("init_ready_low", {31'b0, bp.ready}, 0);
            tick();
        end
        chk("ready_high", {31'b0, bp.ready}, 1);
        probe(16'h0123);
        chk("miss_tag", {31'b0, bp.tag_match}, 0);
        chk("miss_npc", {16'b0, bp.npc}, 32'h0124);

        // BTB install, read-during-write sees old contents
        bp.update_btb = 1; bp.pc_btb = 16'h0205; bp.btb_target = 16'h0300;
        probe(16'h0205);
        chk("rdw_old_tag", {31'b0, bp.tag_match}, 0);
        tick(); bp.update_btb = 0; #1;
        chk("hit_tag", {31'b0, bp.tag_match}, 1);
        chk("hit_taken", {31'b0, bp.pred_taken}, 1);
        chk("hit_npc", {16'b0, bp.npc}, 32'h0300);
        probe(16'h0305);
        chk("alias_tag", {31'b0, bp.tag_match}, 0);
        chk("alias_npc", {16'b0, bp.npc}, 32'h0306);

        // Saturation at 0 and at 3
        probe(16'h0205);
        pht_pulse(16'h0205, 4'h0, 0, 0);
        pht_pulse(16'h0205, 4'h0, 0, 0); #1;
        chk("nt2_taken", {31'b0, bp.pred_taken}, 0);
        chk("nt2_npc", {16'b0, bp.npc}, 32'h0206);
        pht_pulse(16'h0205, 4'h0, 0, 0); #1;
        chk("nt3_taken", {31'b0, bp.pred_taken}, 0);
        for (int k = 0; k < 3; k++) pht_pulse(16'h0205, 4'h0, 1, 0);
        pht_pulse(16'h000F, 4'h0, 0, 0); #1;   // restore GHR to 0 via unrelated entry
        chk("t3_taken", {31'b0, bp.pred_taken}, 1);
        pht_pulse(16'h0205, 4'h0, 0, 0); #1;   // 3 -> 2 still taken
        chk("sat3_taken", {31'b0, bp.pred_taken}, 1);

        // Gshare separation
        btb_install(16'h0010, 16'h0ABC);
        pht_pulse(16'h0010, 4'h1, 0, 0);
        pht_pulse(16'h0010, 4'h1, 0, 0);
        pht_pulse(16'h000F, 4'h0, 0, 0);       // GHR=0
        probe(16'h0010);
        chk("gs_ghr0_taken", {31'b0, bp.pred_taken}, 1);
        chk("gs_ghr0_npc", {16'b0, bp.npc}, 32'h0ABC);
        pht_pulse(16'h000E, 4'h0, 1, 0); #1;   // GHR=1
        chk("gs_ghr1_ghr", {28'b0, bp.pred_ghr}, 1);
        chk("gs_ghr1_taken", {31'b0, bp.pred_taken}, 0);
        chk("gs_ghr1_npc", {16'b0, bp.npc}, 32'h0011);

        // Wrap: hit at 0xFFFF predicted not taken
        btb_install(16'hFFFF, 16'h1234);
        pht_pulse(16'h000F, 4'h0, 0, 0);
        probe(16'hFFFF);
        chk("wrap_tag", {31'b0, bp.tag_match}, 1);
        chk("wrap_npc", {16'b0, bp.npc}, 32'h0000);

        // Simultaneous BTB and PHT update
        bp.update_btb = 1; bp.pc_btb = 16'h0207; bp.btb_target = 16'h0400;
        pht_pulse(16'h0207, 4'h0, 1, 0);
        bp.update_btb = 0;
        probe(16'h0207);
        chk("simul_npc", {16'b0, bp.npc}, 32'h0400);

        // Reset mid-INIT restarts the sequence; updates during INIT are dropped
        reset = 1; tick(); reset = 0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1; tick(); reset = 0;
        bp.update_btb = 1; bp.pc_btb = 16'h0205; bp.btb_target = 16'h0300;
        for (int k = 0; k < N; k++) begin
            chk("reinit_ready_low", {31'b0, bp.ready}, 0);
            tick();
        end
        bp.update_btb = 0;
        chk("reinit_ready_high", {31'b0, bp.ready}, 1);
        probe(16'h0205);
        chk("dropped_btb", {31'b0, bp.tag_match}, 0);

        // Stats: 10 resolutions, 3 mispredicted
        for (int k = 0; k < 10; k++) pht_pulse(16'h0100 + 16'(k), 4'(k), k[0], k < 3);
`ifdef BP_STATS_EN
        chk("stat_br", bp.stat_branches, 10);
        chk("stat_mp", bp.stat_mispredicts, 3);
`else
        chk("stat_br_off", bp.stat_branches, 0);
        chk("stat_mp_off", bp.stat_mispredicts, 0);
`endif
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the BTB/2-bit-BHT front-end predictor. It combines a tagged, direct-mapped BTB that holds full-width targets and valid bits with a gshare pattern history table (PHT) of saturating counters, indexed by PC XOR global history. Tables are cleared by a one-entry-per-cycle init sequencer, so no single-cycle array reset is needed. Sits beside the IF-stage PC mux; ID installs BTB entries, EX (or ID for JPR) resolves outcomes.

Parameters:
WORD_SIZE, 16, PC/target width
IDX_BITS, 8, BTB/PHT index width; depth = 2**IDX_BITS
GHR_BITS, 6, global history length; legal range 1..IDX_BITS
CTR_BITS, 2, PHT counter width; legal range >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ready  out  1  high once table init is complete
pc  in  WORD_SIZE  current fetch PC
tag_match  out  1  BTB hit for pc
pred_taken  out  1  predicted taken
npc  out  WORD_SIZE  predicted next PC (combinational)
pred_ghr  out  GHR_BITS  GHR used for this prediction; carried down the pipe
update_btb  in  1  install/overwrite a BTB entry
pc_btb  in  WORD_SIZE  PC of the branch being installed
btb_target  in  WORD_SIZE  target to install
update_pht  in  1  branch resolved this cycle
pc_outcome  in  WORD_SIZE  PC of the resolved branch
ghr_outcome  in  GHR_BITS  pred_ghr that travelled with the resolved branch
branch_outcome  in  1  1 = taken
mispredict  in  1  resolved branch was mispredicted; qualified by update_pht
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  mispredict count

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- FSM states: INIT, RUN.
- On reset: state=INIT, init_idx=0, GHR=0, ready=0, stats=0.
- INIT, each cycle: entry init_idx gets valid=0, tag=0, target=0, and PHT[init_idx]=2**(CTR_BITS-1) (weakly taken). init_idx increments.
- INIT exit: the cycle that writes index 2**IDX_BITS-1 moves to RUN. ready=1 from the next cycle, exactly 2**IDX_BITS cycles after reset deasserts.
- Reset asserted mid-INIT or during RUN restarts INIT from index 0.
- While ready=0: tag_match=0, pred_taken=0, npc=pc+1. update_btb and update_pht are ignored; GHR and stats hold.
- Prediction is combinational from pc.
  - idx=pc[IDX_BITS-1:0]; tag=pc[WORD_SIZE-1:IDX_BITS].
  - tag_match = ready & valid[idx] & (tag==tags[idx]).
  - pidx = idx XOR zero-extended GHR.
  - pred_taken = tag_match & PHT[pidx][CTR_BITS-1].
  - npc = pred_taken ? target[idx] : pc+1, with pc+1 wrapping modulo 2**WORD_SIZE.
  - pred_ghr = GHR.
- update_btb, at posedge: entry pc_btb[IDX_BITS-1:0] gets valid=1, tag=pc_btb upper bits, target=btb_target. Overwrites any existing entry. PHT is untouched.
- update_pht, at posedge:
  - uidx = pc_outcome[IDX_BITS-1:0] XOR ghr_outcome.
  - Counter increments on taken, decrements on not-taken, saturating at all-ones and at 0.
  - GHR <= {ghr_outcome[GHR_BITS-2:0], branch_outcome}; with GHR_BITS=1, GHR <= branch_outcome. History is repaired from the resolving branch, not speculative.
- Simultaneous update_btb and update_pht: both apply. Same-entry PHT and BTB writes are independent.
- Read-during-write: combinational outputs reflect pre-edge contents and see new values the cycle after the edge.
- PHT index collisions between different PCs/histories are permitted (aliasing by design).

Optional Feature:
BP_STATS_EN
- Defined: on each update_pht in RUN, stat_branches increments; if mispredict=1, stat_mispredicts also increments. Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: no counter logic is instantiated; both outputs are tied to 0 and mispredict is unused.

Test Plan:
- Reset for 1 cycle with IDX_BITS=4 -> ready=0 for exactly 16 cycles, then 1; probe pc=16'h0123 -> tag_match=0, npc=16'h0124.
- update_btb pc_btb=16'h0205, btb_target=16'h0300; next cycle pc=16'h0205 -> tag_match=1, pred_taken=1 (weak-taken init), npc=16'h0300; pc=16'h0305 (same idx, different tag) -> tag_match=0, npc=16'h0306.
- Saturation: update_pht not-taken twice at pc 16'h0205 with ghr_outcome=0 (GHR holds 0) -> pred_taken=0, npc=16'h0206; a third not-taken keeps the counter at 0; then three taken -> counter=3, pred_taken=1.
- Gshare separation: train pc=16'h0010 not-taken under ghr_outcome=6'h01 until the counter reaches 0 -> with GHR=0 the prediction is still taken; with GHR=1 it is not taken. pc=16'hFFFF with a hit not taken -> npc=16'h0000 (wrap).
- Reset asserted at INIT cycle 5 -> init restarts; ready rises 2**IDX_BITS cycles after that reset; an update_btb issued while ready=0 is dropped (no hit afterwards).
- BP_STATS_EN: 10 update_pht pulses, 3 with mispredict=1 -> stat_branches=10, stat_mispredicts=3; without the macro both read 0.
